// File: rtl/fp_out_wrapper_ctrl.sv
// fp_out_wrapper_ctrl: captures FP core results on fpDone and hands them to a consumer over
// a four-phase outReady/outAccept handshake, with one presented entry (cur) and one skid
// entry (pend).
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   fpDone         one-cycle result strobe from the FP core; fpResult valid alongside
//   outAccept      consumer acknowledge level
//   outReady       outData holds a valid result (or half-result)
//   outData        presented result; DATA_W/2 wide when OUT_SPLIT_EN is defined
//   outHalf        0 = low/whole word, 1 = high half (tied 0 without OUT_SPLIT_EN)
//   resultTaken    one-cycle pulse in the cycle a result finishes delivery
//   overrun        sticky flag, a result arrived with both entries full and was dropped
//   occupancy      number of results held, 0..2
// Optional feature macro: OUT_SPLIT_EN sends each result as two half-width transfers.
module fp_out_wrapper_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fpDone,
   input  logic [DATA_W-1:0]     fpResult,
   input  logic                  outAccept,
   output logic                  outReady,
`ifdef OUT_SPLIT_EN
   output logic [DATA_W/2-1:0]   outData,
`else
   output logic [DATA_W-1:0]     outData,
`endif
   output logic                  outHalf,
   output logic                  resultTaken,
   output logic                  overrun,
   output logic [1:0]            occupancy
);
`ifdef OUT_SPLIT_EN
   typedef enum logic [2:0] {IDLE, PRES_LO, REL_LO, PRES_HI, REL_HI} stateT;
   localparam stateT LAST_REL = REL_HI;
`else
   typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} stateT;
   localparam stateT LAST_REL = RELEASE;
`endif
   stateT state, nxtState;
   logic [DATA_W-1:0] cur, pend, curN, pendN;
   logic curV, pendV, curVN, pendVN, ovrN, exitRel;
   // The last release state ending is the only point where a result is retired.
   assign exitRel = state == LAST_REL && !outAccept;
   assign resultTaken = exitRel;
`ifdef OUT_SPLIT_EN
   assign outReady = state == PRES_LO || state == PRES_HI;
   assign outHalf = state == PRES_HI || state == REL_HI;
   assign outData = outHalf ? cur[DATA_W-1:DATA_W/2] : cur[DATA_W/2-1:0];
`else
   assign outReady = state == PRESENT;
   assign outHalf = 1'b0;
   assign outData = cur;
`endif
   always_comb begin
      nxtState = state;
      curN = cur;
      pendN = pend;
      curVN = curV;
      pendVN = pendV;
      ovrN = overrun;
      case (state)
`ifdef OUT_SPLIT_EN
         IDLE:    nxtState = fpDone ? PRES_LO : IDLE;
         PRES_LO: nxtState = outAccept ? REL_LO : PRES_LO;
         REL_LO:  nxtState = outAccept ? REL_LO : PRES_HI;
         PRES_HI: nxtState = outAccept ? REL_HI : PRES_HI;
         REL_HI:  nxtState = outAccept ? REL_HI : (pendV || fpDone) ? PRES_LO : IDLE;
`else
         IDLE:    nxtState = fpDone ? PRESENT : IDLE;
         PRESENT: nxtState = outAccept ? RELEASE : PRESENT;
         RELEASE: nxtState = outAccept ? RELEASE : (pendV || fpDone) ? PRESENT : IDLE;
`endif
         default: nxtState = IDLE;
      endcase
      if (state == IDLE && fpDone) begin
         curN = fpResult;
         curVN = 1'b1;
      end else if (exitRel) begin
         // Skid entry has priority; a same-edge fpDone refills the skid slot.
         curN = pendV ? pend : fpResult;
         curVN = pendV || fpDone;
         pendN = (pendV && fpDone) ? fpResult : pend;
         pendVN = pendV && fpDone;
      end else if (fpDone && state != IDLE) begin
         pendN = pendV ? pend : fpResult;
         pendVN = 1'b1;
         ovrN = overrun || pendV;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cur <= '0;
         pend <= '0;
         curV <= 1'b0;
         pendV <= 1'b0;
         overrun <= 1'b0;
         occupancy <= 2'd0;
      end else begin
         state <= nxtState;
         cur <= curN;
         pend <= pendN;
         curV <= curVN;
         pendV <= pendVN;
         overrun <= ovrN;
         occupancy <= {1'b0, curVN} + {1'b0, pendVN};
      end
   end
endmodule
